lfsr_burst_ctrl: RTL and testbench

//  Sequencer for a Fibonacci LFSR bit generator. Accepts a seed and a burst length,

---
 rtl/lfsr_burst_ctrl_pkg.sv | 8 +
 rtl/lfsr_burst_ctrl_if.sv | 26 ++
 rtl/lfsr_burst_ctrl_core.sv | 26 ++
 rtl/lfsr_burst_ctrl.sv | 84 ++++++++
 tb/tb_lfsr_burst_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_burst_ctrl_pkg.sv
// Shared types and constants for the LFSR burst sequencer.
package lfsr_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} lfsr_ctrl_state_t;

   localparam logic [3:0] DEFAULT_TAPS_4 = 4'b1100;

endpackage

// File: rtl/lfsr_burst_ctrl_if.sv
// Control and bit-stream bundle between the control master, the sequencer and the bit consumer.
interface lfsr_burst_ctrl_if #(
   parameter int W  = 4,
   parameter int LW = 8
);
   logic          seed_load;
   logic [W-1:0]  seed;
   logic          start;
   logic [LW-1:0] len;
   logic          abort;
   logic          bit_valid;
   logic          bit_ready;
   logic          bit_out;
   logic          busy;
   logic          done;

   modport master (
      output seed_load, seed, start, len, abort, bit_ready,
      input  bit_valid, bit_out, busy, done
   );

   modport slave (
      input  seed_load, seed, start, len, abort, bit_ready,
      output bit_valid, bit_out, busy, done
   );
endinterface

// File: rtl/lfsr_burst_ctrl_core.sv
// Fibonacci LFSR state register: async reset to all ones, zero-guarded load, single step.
module lfsr_core
   import lfsr_pkg::*;
#(
   parameter int           W    = 4,
   parameter logic [W-1:0] TAPS = W'(DEFAULT_TAPS_4)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         step,
   output logic [W-1:0] state
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= '1;
      else if (load)
         // An all-zero state would lock the LFSR, so it is replaced by all ones.
         state <= (load_val == '0) ? '1 : load_val;
      else if (step)
         state <= {state[W-2:0], ^(state & TAPS)};
   end

endmodule

// File: rtl/lfsr_burst_ctrl.sv
// Burst sequencer: emits len LFSR bits over valid/ready, advancing only on accepted bits.
module lfsr_burst_ctrl
   import lfsr_pkg::*;
#(
   parameter int           W    = 4,
   parameter logic [W-1:0] TAPS = W'(DEFAULT_TAPS_4),
   parameter int           LW   = 8
) (
   input  logic               clk,
   input  logic               reset,
   lfsr_burst_ctrl_if.slave   bus
);

   lfsr_ctrl_state_t state, state_next;
   logic [LW-1:0]    count;
   logic [W-1:0]     s;
   logic             hs;
   logic             load;

   // Abort wins over a same-cycle handshake, so that bit stays unconsumed.
   assign hs   = (state == RUN) && bus.bit_ready && !bus.abort;
   assign load = (state == IDLE) && bus.seed_load;

   lfsr_core #(.W(W), .TAPS(TAPS)) u_core (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_val (bus.seed),
      .step     (hs),
      .state    (s)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (bus.start) state_next = (bus.len != '0) ? RUN : DONE;
         RUN: begin
            if (bus.abort)                    state_next = IDLE;
            else if (hs && count == LW'(1))   state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else begin
         case (state)
            IDLE: if (bus.start) count <= bus.len;
            RUN: begin
               if (bus.abort)                count <= '0;
               else if (hs && count != '0)   count <= count - LW'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.bit_valid = 1'b0;
      bus.busy      = 1'b0;
      bus.done      = 1'b0;
      bus.bit_out   = s[W-1];
      case (state)
         RUN: begin
            bus.bit_valid = 1'b1;
            bus.busy      = 1'b1;
         end
         DONE: begin
            bus.done = 1'b1;
            bus.busy = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Directed and randomized checks of lfsr_burst_ctrl against a bit-stream reference model.
module tb_lfsr_burst_ctrl;
   import lfsr_pkg::*;

   localparam int           W    = 4;
   localparam int           LW   = 8;
   localparam logic [W-1:0] TAPS = DEFAULT_TAPS_4;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   lfsr_burst_ctrl_if #(.W(W), .LW(LW)) bus ();

   lfsr_burst_ctrl #(.W(W), .TAPS(TAPS), .LW(LW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: window of the next W output bits (front = bit_out), plus burst bookkeeping.
   bit win[$];
   int remaining;
   bit m_run, m_done;
   bit got[$];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   function automatic void m_reset();
      win.delete();
      for (int i = 0; i < W; i++) win.push_back(1'b1);
      remaining = 0;
      m_run     = 1'b0;
      m_done    = 1'b0;
   endfunction

   function automatic void m_seed(input logic [W-1:0] sd);
      logic [W-1:0] v;
      v = (sd == '0) ? '1 : sd;
      win.delete();
      for (int i = W - 1; i >= 0; i--) win.push_back(v[i]);
   endfunction

   // The new bit entering the window is the XOR of the tapped window positions.
   function automatic void m_advance();
      bit f;
      f = 1'b0;
      for (int i = 0; i < W; i++) if (TAPS[i]) f ^= win[W-1-i];
      void'(win.pop_front());
      win.push_back(f);
   endfunction

   task automatic check_outs(input string tag);
      chk({tag, ".busy"},      bus.busy,      m_run || m_done);
      chk({tag, ".bit_valid"}, bus.bit_valid, m_run);
      chk({tag, ".done"},      bus.done,      m_done);
      chk({tag, ".bit_out"},   bus.bit_out,   win[0]);
   endtask

   task automatic step(input logic sl, input logic [W-1:0] sd, input logic st,
                       input logic [LW-1:0] ln, input logic ab, input logic rdy,
                       input string tag);
      bus.seed_load = sl;
      bus.seed      = sd;
      bus.start     = st;
      bus.len       = ln;
      bus.abort     = ab;
      bus.bit_ready = rdy;
      if (bus.bit_valid && rdy && !ab) got.push_back(bus.bit_out);
      if (m_done)
         m_done = 1'b0;
      else if (m_run) begin
         if (ab) m_run = 1'b0;
         else if (rdy) begin
            m_advance();
            remaining--;
            if (remaining == 0) begin
               m_run  = 1'b0;
               m_done = 1'b1;
            end
         end
      end else begin
         if (sl) m_seed(sd);
         if (st) begin
            if (ln != '0) begin
               m_run     = 1'b1;
               remaining = int'(ln);
            end else
               m_done = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      check_outs(tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, tag);
   endtask

   initial begin
      logic [7:0] exp8;
      int         k;
      exp8 = 8'b11110001;
      bus.seed_load = 1'b0;
      bus.seed      = '0;
      bus.start     = 1'b0;
      bus.len       = '0;
      bus.abort     = 1'b0;
      bus.bit_ready = 1'b0;
      m_reset();

      // 1: reset held two cycles, then quiet idle
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset");
      chk("reset.bit_out_one", bus.bit_out, 1'b1);
      reset = 1'b0;
      idle(2, "post_reset");

      // 2: full-rate burst of 8 from 1111
      got.delete();
      step(1'b1, 4'hF, 1'b1, 8'd8, 1'b0, 1'b0, "t2_start");
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, "t2_run");
      chk("t2.done_pulse", bus.done, 1'b1);
      step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, "t2_end");
      chk("t2.busy_clear", bus.busy, 1'b0);
      chk("t2.count", got.size(), 8);
      for (int i = 0; i < 8 && i < got.size(); i++) chk("t2.bit", got[i], exp8[7-i]);

      // 3: same burst with ready toggling
      got.delete();
      step(1'b1, 4'hF, 1'b1, 8'd8, 1'b0, 1'b0, "t3_start");
      k = 0;
      while (!m_done && k < 32) begin
         step(1'b0, '0, 1'b0, '0, 1'b0, (k % 2) == 0, "t3_run");
         k++;
      end
      chk("t3.done_pulse", bus.done, 1'b1);
      chk("t3.count", got.size(), 8);
      for (int i = 0; i < 8 && i < got.size(); i++) chk("t3.bit", got[i], exp8[7-i]);
      idle(1, "t3_end");

      // 4: zero seed loads all ones; zero-length burst pulses done only
      got.delete();
      step(1'b1, 4'h0, 1'b1, 8'd3, 1'b0, 1'b0, "t4_start");
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, "t4_run");
      idle(1, "t4_done");
      chk("t4.first_bit", got.size() > 0 ? got[0] : 1'bx, 1'b1);
      step(1'b0, '0, 1'b1, 8'd0, 1'b0, 1'b1, "t4_len0");
      chk("t4.len0_done", bus.done, 1'b1);
      chk("t4.len0_valid", bus.bit_valid, 1'b0);
      idle(1, "t4_end");

      // 5: abort after 3 bits, then a 2-bit burst continues the sequence
      got.delete();
      step(1'b1, 4'hF, 1'b1, 8'd8, 1'b0, 1'b0, "t5_start");
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, "t5_run");
      step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, "t5_abort");
      chk("t5.abort_idle", bus.busy, 1'b0);
      chk("t5.abort_nodone", bus.done, 1'b0);
      step(1'b0, '0, 1'b1, 8'd2, 1'b0, 1'b0, "t5_restart");
      for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, "t5_run2");
      idle(1, "t5_end");
      chk("t5.count", got.size(), 5);
      for (int i = 0; i < 5 && i < got.size(); i++) chk("t5.bit", got[i], exp8[7-i]);

      // 6: asynchronous reset mid-burst
      step(1'b1, 4'h5, 1'b1, 8'd6, 1'b0, 1'b0, "t6_start");
      step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, "t6_run");
      #2 reset = 1'b1;
      #1;
      m_reset();
      chk("t6.async_busy", bus.busy, 1'b0);
      chk("t6.async_valid", bus.bit_valid, 1'b0);
      chk("t6.async_bit", bus.bit_out, 1'b1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      got.delete();
      step(1'b0, '0, 1'b1, 8'd1, 1'b0, 1'b0, "t6_start2");
      step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, "t6_run2");
      chk("t6.done_pulse", bus.done, 1'b1);
      chk("t6.bit", got.size() > 0 ? got[0] : 1'bx, 1'b1);
      idle(1, "t6_end");

      // Randomized traffic, including commands issued while busy
      for (int i = 0; i < 300; i++) begin
         step(($urandom % 6) == 0, W'($urandom), ($urandom % 3) == 0,
              LW'($urandom_range(0, 6)), ($urandom % 12) == 0,
              ($urandom % 3) != 0, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
